// File: rtl/data_bus_responder.sv
// Data-memory responder for the CPU MEM stage: byte-enabled data RAM plus a memory-mapped countdown timer with irq.
// Defining DM_WRITE_LOG_EN prints a trace line for every effective RAM write.
`timescale 1ns/1ps
module data_bus_responder #(
    parameter int          DM_WORDS = 3072,
    parameter logic [31:0] TMR_BASE = 32'h7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    input  logic [31:0] m_inst_addr,
    output logic [31:0] m_data_rdata,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} tmr_state_t;

    localparam logic [31:0] RAM_BYTES = 32'(DM_WORDS * 4);

    logic [31:0] ram [DM_WORDS];

    logic        ram_sel;
    logic        tmr_sel;
    logic [11:0] ram_idx;
    logic [31:0] tmr_off;
    logic [1:0]  tmr_word;
    logic [31:0] ram_word;
    logic [31:0] merged_word;
    logic        ram_we;
    logic        ctrl_wr;
    logic        preset_wr;
    logic        unused_bits;

    logic        tmr_en;
    logic [1:0]  tmr_mode;
    logic        tmr_im;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;

    tmr_state_t  state;
    tmr_state_t  next_state;
    logic [31:0] next_count;
    logic        clr_en;
    logic        set_flag;

    assign ram_sel   = (m_data_addr < RAM_BYTES);
    assign tmr_sel   = (m_data_addr >= TMR_BASE) && (m_data_addr < TMR_BASE + 32'd12);
    assign ram_idx   = m_data_addr[13:2];
    assign tmr_off   = m_data_addr - TMR_BASE;
    assign tmr_word  = tmr_off[3:2];
    assign ram_word  = ram_sel ? ram[ram_idx] : 32'h0;
    assign ram_we    = ram_sel && (m_data_byteen != 4'b0000);
    assign ctrl_wr   = tmr_sel && (m_data_byteen == 4'b1111) && (tmr_word == 2'd0);
    assign preset_wr = tmr_sel && (m_data_byteen == 4'b1111) && (tmr_word == 2'd1);
    assign irq       = irq_flag & tmr_im;

    always_comb begin
        merged_word = ram_word;
        for (int i = 0; i < 4; i++) begin
            if (m_data_byteen[i]) begin
                merged_word[8*i +: 8] = m_data_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        m_data_rdata = 32'h0;
        if (ram_sel) begin
            m_data_rdata = ram_word;
        end else if (tmr_sel) begin
            case (tmr_word)
                2'd0:    m_data_rdata = {28'h0, tmr_im, tmr_mode, tmr_en};
                2'd1:    m_data_rdata = preset;
                2'd2:    m_data_rdata = count;
                default: m_data_rdata = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                ram[i] <= 32'h0;
            end
        end else if (ram_we) begin
            ram[ram_idx] <= merged_word;
        end
    end

    // Timer next-state logic; MODE values other than 1 all behave as one-shot.
    always_comb begin
        next_state = state;
        next_count = count;
        clr_en     = 1'b0;
        set_flag   = 1'b0;
        case (state)
            IDLE: begin
                if (tmr_en) next_state = LOAD;
            end
            LOAD: begin
                next_count = preset;
                next_state = CNT;
            end
            CNT: begin
                if (!tmr_en) begin
                    next_state = IDLE;
                end else if (count > 32'd1) begin
                    next_count = count - 32'd1;
                end else begin
                    next_count = 32'h0;
                    next_state = INT;
                end
            end
            INT: begin
                set_flag = 1'b1;
                if (tmr_mode == 2'd1) begin
                    next_state = LOAD;
                end else begin
                    clr_en     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Bus writes to CTRL/PRESET are applied after the FSM update, so the CPU wins any conflict.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= 32'h0;
            preset   <= 32'h0;
            tmr_en   <= 1'b0;
            tmr_mode <= 2'd0;
            tmr_im   <= 1'b0;
            irq_flag <= 1'b0;
        end else begin
            state <= next_state;
            count <= next_count;
            if (ctrl_wr) begin
                {tmr_im, tmr_mode, tmr_en} <= m_data_wdata[3:0];
            end else if (clr_en) begin
                tmr_en <= 1'b0;
            end
            if (preset_wr) begin
                preset <= m_data_wdata;
            end
            if (ctrl_wr) begin
                irq_flag <= 1'b0;
            end else if (set_flag) begin
                irq_flag <= 1'b1;
            end
        end
    end

`ifdef DM_WRITE_LOG_EN
    always_ff @(posedge clk) begin
        if (!reset && ram_we) begin
            $display("%d@%h: *%h <= %h", $time, m_inst_addr, {m_data_addr[31:2], 2'b00}, merged_word);
        end
    end
    assign unused_bits = ^{tmr_off[31:4], tmr_off[1:0]};
`else
    assign unused_bits = ^{m_inst_addr, tmr_off[31:4], tmr_off[1:0]};
`endif

endmodule

// File: tb/tb_data_bus_responder.sv
// Self-checking bench for data_bus_responder: directed vector table, timer sequences,
// and randomized traffic compared against a byte-level behavioural model.
`timescale 1ns/1ps
module tb_data_bus_responder;

    logic        clk;
    logic        reset;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_inst_addr;
    logic [31:0] m_data_rdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    data_bus_responder dut (
        .clk           (clk),
        .reset         (reset),
        .m_data_addr   (m_data_addr),
        .m_data_wdata  (m_data_wdata),
        .m_data_byteen (m_data_byteen),
        .m_inst_addr   (m_inst_addr),
        .m_data_rdata  (m_data_rdata),
        .irq           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: RAM as a flat byte array, timer as a phase plus counter.
    localparam int PH_IDLE = 0, PH_LOAD = 1, PH_COUNT = 2, PH_FIRE = 3;
    logic [7:0]  mem_b [12288];
    logic        m_en, m_im, m_flag;
    logic [1:0]  m_mode;
    logic [31:0] m_preset, m_count;
    int          m_phase;

    function automatic int tmr_reg(input logic [31:0] a);
        if (a >= 32'h7F00 && a < 32'h7F0C) return int'((a - 32'h7F00) / 4);
        return -1;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int base;
        base = int'(a & ~32'd3);
        if (a < 32'd12288) return {mem_b[base+3], mem_b[base+2], mem_b[base+1], mem_b[base]};
        case (tmr_reg(a))
            0:       return {28'h0, m_im, m_mode, m_en};
            1:       return m_preset;
            2:       return m_count;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step(input logic rst, input logic [31:0] a, input logic [31:0] w,
                              input logic [3:0] b);
        bit fire;
        int ph;
        logic [31:0] cnt;
        if (rst) begin
            for (int i = 0; i < 12288; i++) mem_b[i] = 8'h0;
            m_en = 0; m_im = 0; m_flag = 0; m_mode = 0;
            m_preset = 0; m_count = 0; m_phase = PH_IDLE;
            return;
        end
        fire = 0; ph = m_phase; cnt = m_count;
        if (m_phase == PH_IDLE && m_en) ph = PH_LOAD;
        else if (m_phase == PH_LOAD) begin cnt = m_preset; ph = PH_COUNT; end
        else if (m_phase == PH_COUNT) begin
            if (!m_en) ph = PH_IDLE;
            else if (m_count > 1) cnt = m_count - 1;
            else begin cnt = 0; ph = PH_FIRE; end
        end else if (m_phase == PH_FIRE) begin
            fire = 1;
            if (m_mode == 2'd1) ph = PH_LOAD;
            else begin ph = PH_IDLE; m_en = 0; end
        end
        m_phase = ph; m_count = cnt;
        if (a < 32'd12288)
            for (int i = 0; i < 4; i++)
                if (b[i]) mem_b[int'(a & ~32'd3) + i] = w[8*i +: 8];
        if (b == 4'hF && tmr_reg(a) == 0) begin
            {m_im, m_mode, m_en} = w[3:0];
            m_flag = 0;
        end else if (fire) m_flag = 1;
        if (b == 4'hF && tmr_reg(a) == 1) m_preset = w;
    endtask

    task automatic applyStimulus(input logic rst, input logic [31:0] a, input logic [31:0] w,
                                 input logic [3:0] b);
        reset = rst; m_data_addr = a; m_data_wdata = w; m_data_byteen = b;
        m_inst_addr = 32'h1000 + a;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string what, input int tag, input logic [31:0] exp_r,
                               input logic exp_i);
        checks++;
        if (m_data_rdata !== exp_r) begin
            errors++;
            $display("[TB] FAIL %s#%0d rdata got %h expected %h", what, tag, m_data_rdata, exp_r);
        end
        checks++;
        if (irq !== exp_i) begin
            errors++;
            $display("[TB] FAIL %s#%0d irq got %b expected %b", what, tag, irq, exp_i);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_step(reset, m_data_addr, m_data_wdata, m_data_byteen);
        #1;
    endtask

    task automatic stepModelCheck(input string what, input int tag, input logic rst,
                                  input logic [31:0] a, input logic [31:0] w, input logic [3:0] b);
        applyStimulus(rst, a, w, b);
        checkOutput(what, tag, model_read(a), m_flag & m_im);
        advance();
    endtask

    task automatic stepConstCheck(input string what, input int tag, input logic [31:0] a,
                                  input logic [31:0] w, input logic [3:0] b,
                                  input logic [31:0] exp_r, input logic exp_i);
        applyStimulus(1'b0, a, w, b);
        checkOutput(what, tag, exp_r, exp_i);
        advance();
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  byteen;
        logic [31:0] exp_rdata;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] w, input logic [3:0] b,
                                input logic [31:0] r, input logic i);
        vec_t v;
        v.addr = a; v.wdata = w; v.byteen = b; v.exp_rdata = r; v.exp_irq = i;
        return v;
    endfunction

    initial begin
        int exp_c0[9];
        logic exp_i0[9];
        int exp_c1[13];
        logic exp_i1[13];
        bit found;
        logic [31:0] a, w;
        logic [3:0] b;
        logic rst;
        int sel;

        exp_c0 = '{0, 0, 5, 4, 3, 2, 1, 0, 0};
        exp_i0 = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        exp_c1 = '{0, 0, 3, 2, 1, 0, 0, 3, 2, 1, 0, 0, 3};
        exp_i1 = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};

        vecs.push_back(mk(32'h0000, 0, 4'h0, 32'h0, 0));
        vecs.push_back(mk(32'h2FFC, 0, 4'h0, 32'h0, 0));
        vecs.push_back(mk(32'h7F08, 0, 4'h0, 32'h0, 0));
        vecs.push_back(mk(32'h0010, 32'hAABBCCDD, 4'hF, 32'h0, 0));
        vecs.push_back(mk(32'h0010, 32'h00001100, 4'h2, 32'hAABBCCDD, 0));
        vecs.push_back(mk(32'h0010, 0, 4'h0, 32'hAABB11DD, 0));
        vecs.push_back(mk(32'h4000, 32'h12345678, 4'hF, 32'h0, 0));
        vecs.push_back(mk(32'h4000, 0, 4'h0, 32'h0, 0));
        vecs.push_back(mk(32'h0012, 0, 4'h0, 32'hAABB11DD, 0));
        vecs.push_back(mk(32'h3000, 0, 4'h0, 32'h0, 0));
        vecs.push_back(mk(32'h2FFC, 32'h11223344, 4'hF, 32'h0, 0));
        vecs.push_back(mk(32'h2FFC, 0, 4'h0, 32'h11223344, 0));
        vecs.push_back(mk(32'h7F08, 32'hFFFFFFFF, 4'hF, 32'h0, 0));
        vecs.push_back(mk(32'h7F08, 0, 4'h0, 32'h0, 0));
        vecs.push_back(mk(32'h7F04, 32'h00000005, 4'h3, 32'h0, 0));
        vecs.push_back(mk(32'h7F04, 0, 4'h0, 32'h0, 0));
        vecs.push_back(mk(32'h7F00, 32'hFFFFFFFF, 4'hE, 32'h0, 0));
        vecs.push_back(mk(32'h7F00, 0, 4'h0, 32'h0, 0));
        vecs.push_back(mk(32'h7F0C, 0, 4'h0, 32'h0, 0));
        vecs.push_back(mk(32'h7EFC, 0, 4'h0, 32'h0, 0));

        model_step(1'b1, 0, 0, 0);
        applyStimulus(1'b1, 0, 0, 0);
        advance();
        applyStimulus(1'b1, 0, 0, 0);
        advance();

        $display("[TB] directed vector table");
        foreach (vecs[k]) begin
            stepConstCheck("vec", k, vecs[k].addr, vecs[k].wdata, vecs[k].byteen,
                           vecs[k].exp_rdata, vecs[k].exp_irq);
        end

        $display("[TB] one-shot timer");
        stepModelCheck("os_setup", 0, 0, 32'h7F04, 32'd5, 4'hF);
        stepModelCheck("os_setup", 1, 0, 32'h7F00, 32'h9, 4'hF);
        for (int k = 0; k < 9; k++) stepConstCheck("os_count", k, 32'h7F08, 0, 4'h0, exp_c0[k], exp_i0[k]);
        stepConstCheck("os_ctrl", 0, 32'h7F00, 0, 4'h0, 32'h8, 1'b1);
        stepConstCheck("os_ack", 0, 32'h7F00, 32'h8, 4'hF, 32'h8, 1'b1);
        stepConstCheck("os_ctrl", 1, 32'h7F00, 0, 4'h0, 32'h8, 1'b0);

        $display("[TB] auto-reload timer");
        stepModelCheck("ar_setup", 0, 0, 32'h7F04, 32'd3, 4'hF);
        stepModelCheck("ar_setup", 1, 0, 32'h7F00, 32'hB, 4'hF);
        for (int k = 0; k < 13; k++) stepConstCheck("ar_count", k, 32'h7F08, 0, 4'h0, exp_c1[k], exp_i1[k]);
        stepConstCheck("ar_stop", 0, 32'h7F00, 32'h0, 4'hF, 32'hB, 1'b1);
        for (int k = 0; k < 4; k++) stepConstCheck("ar_frozen", k, 32'h7F08, 0, 4'h0, 32'd1, 1'b0);

        $display("[TB] reset during count");
        stepModelCheck("rc_setup", 0, 0, 32'h7F04, 32'd4, 4'hF);
        stepModelCheck("rc_setup", 1, 0, 32'h7F00, 32'h9, 4'hF);
        found = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            if (m_phase == PH_COUNT && m_count == 32'd2) found = 1;
            else stepModelCheck("rc_wait", k, 0, 32'h7F08, 0, 4'h0);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL rc_wait timeout got no COUNT=2 expected COUNT=2 within 30 cycles");
        end
        applyStimulus(1'b1, 32'h7F08, 0, 4'h0);
        checkOutput("rc_pre", 0, 32'd2, 1'b0);
        advance();
        stepConstCheck("rc_count", 0, 32'h7F08, 0, 4'h0, 32'h0, 1'b0);
        stepConstCheck("rc_ctrl", 0, 32'h7F00, 0, 4'h0, 32'h0, 1'b0);
        stepConstCheck("rc_ram", 0, 32'h0010, 0, 4'h0, 32'h0, 1'b0);
        stepConstCheck("rc_half", 0, 32'h7F04, 32'h7, 4'h3, 32'h0, 1'b0);
        stepConstCheck("rc_preset", 0, 32'h7F04, 0, 4'h0, 32'h0, 1'b0);
        for (int k = 0; k < 6; k++) stepConstCheck("rc_quiet", k, 32'h7F08, 0, 4'h0, 32'h0, 1'b0);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 149) == 0);
            sel = $urandom_range(0, 9);
            w = $urandom;
            b = ($urandom_range(0, 2) == 0) ? 4'h0 :
                (($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF);
            case (sel)
                0, 1, 2: a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
                3:       a = 32'h2FC0 + (32'($urandom_range(0, 15)) << 2);
                4:       begin a = 32'h7F00; w = 32'($urandom_range(0, 15)); end
                5:       begin a = 32'h7F04; w = 32'($urandom_range(0, 6)); end
                6:       a = 32'h7F08;
                7: begin
                    case ($urandom_range(0, 3))
                        0: a = 32'h3000;
                        1: a = 32'h4000;
                        2: a = 32'h7F0C;
                        default: a = $urandom | 32'h10000;
                    endcase
                end
                default: begin a = 32'h7F08; b = 4'h0; end
            endcase
            stepModelCheck("rand", n, rst, a, w, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
